move_request_gen: RTL
=====================

MOVE_REQUEST_GEN -- requirements
Module: move_request_gen

Interface
REQ-001 Parameter DB_CYCLES, default 500000, is the number of consecutive stable cycles (10 ms at 50 MHz) needed to accept a button level change.
REQ-002 Parameter REPEAT_DELAY, default 20000000, is the number of cycles (400 ms) from the first request to the first auto-repeat.
REQ-003 Parameter REPEAT_PERIOD, default 7500000, is the number of cycles (150 ms) between auto-repeats.
REQ-004 CLOCK_50  input  1  system clock; the only clock.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 btn_raw  input  4  unsynchronised active-high buttons {left, down, right, up}, already inverted from KEY/SW.
REQ-007 enable  input  1  requests are permitted while high; driven by maze_done.
REQ-008 move_ready  input  1  consumer (player controller) accepts the pending request.
REQ-009 move_valid  output  1  a request is pending.
REQ-010 move_dir  output  4  one-hot direction {left, down, right, up}; valid while move_valid is high.
REQ-011 held_dirs  output  4  debounced button levels.

Function
REQ-012 Each btn_raw bit SHALL pass through a 2-flop synchroniser before debouncing.
REQ-013 A debounced bit SHALL change only after its synchronised input has differed from it for DB_CYCLES consecutive cycles; any intervening agreement restarts the count.
REQ-014 A press event SHALL be a 0->1 transition of a held_dirs bit; on simultaneous press events, priority is up > right > down > left.
REQ-015 The FSM SHALL have states IDLE, DELAY and REPEAT, plus a 2-bit register holding the selected direction.
REQ-016 IDLE: a press event while enable is high SHALL issue a request for that direction, clear the timer and go to DELAY.
REQ-017 DELAY: when the timer reaches REPEAT_DELAY-1, the FSM SHALL issue a request, clear the timer and go to REPEAT.
REQ-018 REPEAT: each time the timer reaches REPEAT_PERIOD-1, the FSM SHALL issue a request and clear the timer.
REQ-019 In DELAY or REPEAT, release of the selected button SHALL return the FSM to IDLE in the next cycle; no further request is issued.
REQ-020 In DELAY or REPEAT, a press event on another button SHALL reselect that direction, issue a request and restart in DELAY (latest press wins).
REQ-021 Issuing a request SHALL set move_valid and load move_dir one cycle after the triggering condition.
REQ-022 move_valid and move_dir SHALL hold stable until a cycle in which move_valid and move_ready are both high; move_valid clears on the next edge.
REQ-023 An issue attempt while an unaccepted request is pending SHALL be dropped; there is no queue, and the pending move_dir is unchanged.
REQ-024 An issue attempt coinciding with acceptance SHALL load the new request, so move_valid stays high with the new move_dir.
REQ-025 enable low SHALL force the FSM to IDLE and clear move_valid on the next edge; buttons held across enable rising SHALL NOT issue a request until released and pressed again.
REQ-026 Timers SHALL be wide enough for max(REPEAT_DELAY, REPEAT_PERIOD) and SHALL never wrap.

Reset
REQ-027 Reset SHALL asynchronously clear the synchronisers, debounced bits (held_dirs=0), debounce counters, timer, FSM (IDLE), move_valid=0 and move_dir=0.
REQ-028 Reset asserted mid-request SHALL drop the pending request, and no request SHALL be issued in the first cycle after release.

Structure
REQ-029 Shared package mm_pkg SHALL hold the direction index constants (DIR_UP=0, DIR_RIGHT=1, DIR_DOWN=2, DIR_LEFT=3) and the FSM state encoding.
REQ-030 Per-bit debounce SHALL be the sub-module debounce_bit (synchroniser plus counter), instantiated four times.

Verification (DB_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=8)
REQ-031 up pulse of 3 cycles -> held_dirs stays 0 and move_valid stays 0.
REQ-032 right held 40 cycles, move_ready=1 -> first move_dir=0010 pulse, then a repeat 20 cycles later, then every 8 cycles until release; none after release.
REQ-033 left and down pressed in the same cycle -> move_dir=0100 (down).
REQ-034 up pressed, move_ready=0 for 30 cycles -> move_valid high with 0001 throughout, repeats dropped; exactly one accept when move_ready rises.
REQ-035 enable=0 with up held, then enable rises -> no request until up is released and pressed again.
REQ-036 reset pulsed while move_valid=1 -> move_valid=0 and move_dir=0 immediately, no request in the first cycle after release.

Source files
------------

// File: rtl/mm_pkg.sv
// Shared constants for the move-request path: direction indices, FSM encoding
// and small direction helpers.
package mm_pkg;

    localparam logic [1:0] DIR_UP    = 2'd0;
    localparam logic [1:0] DIR_RIGHT = 2'd1;
    localparam logic [1:0] DIR_DOWN  = 2'd2;
    localparam logic [1:0] DIR_LEFT  = 2'd3;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DELAY  = 2'd1;
    localparam logic [1:0] ST_REPEAT = 2'd2;

    // Highest-priority set bit of a press vector: up > right > down > left.
    function automatic logic [1:0] prio_dir(input logic [3:0] ev);
        logic [1:0] r;
        r = DIR_LEFT;
        if (ev[DIR_DOWN])  r = DIR_DOWN;
        if (ev[DIR_RIGHT]) r = DIR_RIGHT;
        if (ev[DIR_UP])    r = DIR_UP;
        return r;
    endfunction

    function automatic logic [3:0] dir_onehot(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction

endpackage

// File: rtl/debounce_bit.sv
// One button bit: 2-flop synchroniser followed by a consecutive-difference
// counter; the level flips after DB_CYCLES disagreeing cycles in a row.
module debounce_bit #(
    parameter int DB_CYCLES = 500000
) (
    input  logic clk_sys,
    input  logic rst,
    input  logic raw,
    output logic level
);

    localparam int CW = $clog2(DB_CYCLES + 1);

    logic [1:0]    sync_q, sync_d;
    logic          level_q, level_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        sync_d  = {sync_q[0], raw};
        level_d = level_q;
        cnt_d   = cnt_q;
        if (sync_q[1] == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == CW'(DB_CYCLES - 1)) begin
            level_d = sync_q[1];
            cnt_d   = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            sync_q  <= '0;
            level_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync_q  <= sync_d;
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level = level_q;

endmodule

// File: rtl/move_request_gen.sv
// Debounced four-button move request generator with press, delayed first
// repeat and periodic auto-repeat, handed out over a valid/ready slot.
module move_request_gen
    import mm_pkg::*;
#(
    parameter int DB_CYCLES     = 500000,
    parameter int REPEAT_DELAY  = 20000000,
    parameter int REPEAT_PERIOD = 7500000
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic [3:0] btn_raw,
    input  logic       enable,
    input  logic       move_ready,
    output logic       move_valid,
    output logic [3:0] move_dir,
    output logic [3:0] held_dirs
);

    localparam int TMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int TW   = $clog2(TMAX + 1);

    logic [3:0]    held_w;
    logic [3:0]    held_prev_q, held_prev_d;
    logic [3:0]    press;
    logic [1:0]    state_q, state_d;
    logic [1:0]    dir_sel_q, dir_sel_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          move_valid_q, move_valid_d;
    logic [3:0]    move_dir_q, move_dir_d;
    logic          issue;
    logic          accept;

    for (genvar i = 0; i < 4; i++) begin : g_db
        debounce_bit #(.DB_CYCLES(DB_CYCLES)) u_db (
            .clk_sys (CLOCK_50),
            .rst     (reset),
            .raw     (btn_raw[i]),
            .level   (held_w[i])
        );
    end

    assign press = held_w & ~held_prev_q;

    // A new press always wins over release or timer expiry of the current selection.
    always_comb begin
        held_prev_d = held_w;
        state_d     = state_q;
        dir_sel_d   = dir_sel_q;
        timer_d     = timer_q;
        issue       = 1'b0;
        if (!enable) begin
            state_d = ST_IDLE;
            timer_d = '0;
        end else if (|press) begin
            issue     = 1'b1;
            dir_sel_d = prio_dir(press);
            timer_d   = '0;
            state_d   = ST_DELAY;
        end else begin
            case (state_q)
                ST_DELAY, ST_REPEAT: begin
                    if (!held_w[dir_sel_q]) begin
                        state_d = ST_IDLE;
                        timer_d = '0;
                    end else if (state_q == ST_DELAY && timer_q == TW'(REPEAT_DELAY - 1)) begin
                        issue   = 1'b1;
                        timer_d = '0;
                        state_d = ST_REPEAT;
                    end else if (state_q == ST_REPEAT && timer_q == TW'(REPEAT_PERIOD - 1)) begin
                        issue   = 1'b1;
                        timer_d = '0;
                    end else begin
                        timer_d = timer_q + TW'(1);
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    timer_d = '0;
                end
            endcase
        end
    end

    // Single-entry output slot: an issue while still pending is simply lost.
    always_comb begin
        accept       = move_valid_q & move_ready;
        move_valid_d = move_valid_q;
        move_dir_d   = move_dir_q;
        if (!enable) begin
            move_valid_d = 1'b0;
        end else if (issue && (!move_valid_q || accept)) begin
            move_valid_d = 1'b1;
            move_dir_d   = dir_onehot(dir_sel_d);
        end else if (accept) begin
            move_valid_d = 1'b0;
        end
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            held_prev_q  <= '0;
            state_q      <= ST_IDLE;
            dir_sel_q    <= DIR_UP;
            timer_q      <= '0;
            move_valid_q <= 1'b0;
            move_dir_q   <= '0;
        end else begin
            held_prev_q  <= held_prev_d;
            state_q      <= state_d;
            dir_sel_q    <= dir_sel_d;
            timer_q      <= timer_d;
            move_valid_q <= move_valid_d;
            move_dir_q   <= move_dir_d;
        end
    end

    assign move_valid = move_valid_q;
    assign move_dir   = move_dir_q;
    assign held_dirs  = held_w;

endmodule
